// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction-side initiator for the 8-bit non-pipelined core. Holds the PC,
// fetches one 8-bit instruction at a time over a req/ack handshake, screens
// the 3-bit opcode against the decoder's legal set and presents legal words to
// the control unit over a valid/ready handshake. An illegal opcode (001, 010,
// 011) parks the unit in HALT, so the decoder never sees an undecodable word.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   start          in   one-cycle pulse, begins fetching (IDLE only)
//   imem_req       out  fetch request to instruction memory
//   imem_addr      out  fetch address (equals pc)
//   imem_ack       in   memory returns valid imem_rdata this cycle
//   imem_rdata     in   instruction word
//   instr_valid    out  instr/opcode valid toward decode
//   instr_ready    in   decode/execute accepts the instruction
//   instr          out  registered instruction word
//   opcode         out  instr[7:5]
//   pc             out  address of the instruction held in instr
//   redirect_valid in   next PC is redirect_pc instead of pc+1
//   redirect_pc    in   redirect target
//   illegal_op     out  sticky, an illegal opcode was fetched
//   halted         out  high in the HALT state
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter int                 ADDR_W   = 8,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [7:0]        imem_rdata,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [7:0]        instr,
   output logic [2:0]        opcode,
   output logic [ADDR_W-1:0] pc,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              illegal_op,
   output logic              halted
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_ISSUE = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [7:0]          instr_q, instr_d;
   logic                illegal_q, illegal_d;

   // Legal opcodes: 000 ADD, 100 ADDI, 101 SW, 110 LW, 111 SLL.
   // Every opcode with the top bit set is legal, plus 000.
   function automatic logic is_legal(input logic [2:0] op);
      return op[2] | (op == 3'b000);
   endfunction

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      illegal_d = illegal_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) state_d = S_FETCH;
         end
         S_FETCH: begin
            if (imem_ack) begin
               if (is_legal(imem_rdata[7:5])) begin
                  instr_d = imem_rdata;
                  state_d = S_ISSUE;
               end else begin
                  // The illegal word is never loaded; pc keeps its address.
                  illegal_d = 1'b1;
                  state_d   = S_HALT;
               end
            end
         end
         S_ISSUE: begin
            if (instr_ready) begin
               // Redirect wins over sequential increment; pc+1 wraps silently.
               pc_d    = redirect_valid ? redirect_pc : pc_q + ADDR_W'(1);
               state_d = S_FETCH;
            end
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         pc_q      <= RESET_PC;
         instr_q   <= 8'h00;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         illegal_q <= illegal_d;
      end
   end

   // All handshake outputs decode the registered state only, so neither
   // imem_req nor instr_valid has a combinational path from ack/ready, and
   // the async reset drops them immediately.
   assign imem_req    = (state_q == S_FETCH);
   assign imem_addr   = pc_q;
   assign instr_valid = (state_q == S_ISSUE);
   assign instr       = instr_q;
   assign opcode      = instr_q[7:5];
   assign pc          = pc_q;
   assign illegal_op  = illegal_q;
   assign halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       imem_req;
   logic [7:0] imem_addr;
   logic       imem_ack;
   logic [7:0] imem_rdata;
   logic       instr_valid;
   logic       instr_ready;
   logic [7:0] instr;
   logic [2:0] opcode;
   logic [7:0] pc;
   logic       redirect_valid;
   logic [7:0] redirect_pc;
   logic       illegal_op;
   logic       halted;

   int checks = 0;
   int errors = 0;

   instr_fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .opcode         (opcode),
      .pc             (pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .illegal_op     (illegal_op),
      .halted         (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One record per clock cycle: inputs driven in that cycle and the outputs
   // expected in that same cycle (outputs depend on registered state only).
   typedef struct {
      logic       start;
      logic       ack;
      logic [7:0] rdata;
      logic       ready;
      logic       rv;
      logic [7:0] rpc;
      logic       req;
      logic [7:0] addr;
      logic       valid;
      logic [7:0] ins;
      logic [7:0] pcv;
      logic       ill;
      logic       hlt;
   } vec_t;

   localparam int NV = 22;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic s, input logic a, input logic [7:0] d,
                        input logic r, input logic rv, input logic [7:0] rp);
      start          = s;
      imem_ack       = a;
      imem_rdata     = d;
      instr_ready    = r;
      redirect_valid = rv;
      redirect_pc    = rp;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(0, 0, 8'h00, 0, 0, 8'h00);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      // Test 1..3, 5 and an illegal halt as one cycle-by-cycle table.
      //            st ack rdata  rdy rv rpc   | req addr  v  instr  pc    il h
      vecs[0]  = '{1'b1,1'b0,8'h00,1'b0,1'b0,8'h00, 1'b0,8'h00,1'b0,8'h00,8'h00,1'b0,1'b0};
      vecs[1]  = '{1'b0,1'b1,8'h9A,1'b0,1'b0,8'h00, 1'b1,8'h00,1'b0,8'h00,8'h00,1'b0,1'b0};
      vecs[2]  = '{1'b0,1'b0,8'h00,1'b1,1'b0,8'h00, 1'b0,8'h00,1'b1,8'h9A,8'h00,1'b0,1'b0};
      vecs[3]  = '{1'b0,1'b1,8'h05,1'b0,1'b0,8'h00, 1'b1,8'h01,1'b0,8'h9A,8'h01,1'b0,1'b0};
      // backpressure: ready low 5 cycles, junk ack/start/redirect ignored
      vecs[4]  = '{1'b1,1'b1,8'hFF,1'b0,1'b1,8'h77, 1'b0,8'h01,1'b1,8'h05,8'h01,1'b0,1'b0};
      vecs[5]  = '{1'b0,1'b1,8'hFF,1'b0,1'b0,8'h00, 1'b0,8'h01,1'b1,8'h05,8'h01,1'b0,1'b0};
      vecs[6]  = '{1'b0,1'b1,8'h3F,1'b0,1'b1,8'h22, 1'b0,8'h01,1'b1,8'h05,8'h01,1'b0,1'b0};
      vecs[7]  = '{1'b0,1'b0,8'hFF,1'b0,1'b0,8'h00, 1'b0,8'h01,1'b1,8'h05,8'h01,1'b0,1'b0};
      vecs[8]  = '{1'b0,1'b0,8'h00,1'b0,1'b0,8'h00, 1'b0,8'h01,1'b1,8'h05,8'h01,1'b0,1'b0};
      // handshake with redirect to 0x40
      vecs[9]  = '{1'b0,1'b0,8'h00,1'b1,1'b1,8'h40, 1'b0,8'h01,1'b1,8'h05,8'h01,1'b0,1'b0};
      // three wait states with junk data, word accepted on the 4th cycle
      vecs[10] = '{1'b0,1'b0,8'h3F,1'b0,1'b0,8'h00, 1'b1,8'h40,1'b0,8'h05,8'h40,1'b0,1'b0};
      vecs[11] = '{1'b0,1'b0,8'h55,1'b0,1'b0,8'h00, 1'b1,8'h40,1'b0,8'h05,8'h40,1'b0,1'b0};
      vecs[12] = '{1'b0,1'b0,8'h2A,1'b1,1'b1,8'h99, 1'b1,8'h40,1'b0,8'h05,8'h40,1'b0,1'b0};
      vecs[13] = '{1'b0,1'b1,8'hE1,1'b0,1'b0,8'h00, 1'b1,8'h40,1'b0,8'h05,8'h40,1'b0,1'b0};
      vecs[14] = '{1'b0,1'b0,8'h00,1'b1,1'b1,8'hFF, 1'b0,8'h40,1'b1,8'hE1,8'h40,1'b0,1'b0};
      // redirect during FETCH is ignored
      vecs[15] = '{1'b0,1'b1,8'hC3,1'b0,1'b1,8'h12, 1'b1,8'hFF,1'b0,8'hE1,8'hFF,1'b0,1'b0};
      // handshake at 0xFF without redirect wraps to 0x00
      vecs[16] = '{1'b0,1'b0,8'h00,1'b1,1'b0,8'h00, 1'b0,8'hFF,1'b1,8'hC3,8'hFF,1'b0,1'b0};
      vecs[17] = '{1'b0,1'b1,8'hA0,1'b0,1'b0,8'h00, 1'b1,8'h00,1'b0,8'hC3,8'h00,1'b0,1'b0};
      vecs[18] = '{1'b0,1'b0,8'h00,1'b1,1'b0,8'h00, 1'b0,8'h00,1'b1,8'hA0,8'h00,1'b0,1'b0};
      // illegal opcode 010 at 0x01
      vecs[19] = '{1'b0,1'b1,8'h5F,1'b0,1'b0,8'h00, 1'b1,8'h01,1'b0,8'hA0,8'h01,1'b0,1'b0};
      vecs[20] = '{1'b1,1'b0,8'h00,1'b1,1'b0,8'h00, 1'b0,8'h01,1'b0,8'hA0,8'h01,1'b1,1'b1};
      vecs[21] = '{1'b0,1'b1,8'h00,1'b1,1'b1,8'h30, 1'b0,8'h01,1'b0,8'hA0,8'h01,1'b1,1'b1};

      // ---------------- reset state ----------------
      rst_n = 1'b0;
      drive(0, 0, 8'h00, 0, 0, 8'h00);
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst_req",   {7'd0, imem_req},    8'h00);
      chk("rst_valid", {7'd0, instr_valid}, 8'h00);
      chk("rst_instr", instr,               8'h00);
      chk("rst_pc",    pc,                  8'h00);
      chk("rst_ill",   {7'd0, illegal_op},  8'h00);
      chk("rst_halt",  {7'd0, halted},      8'h00);
      @(negedge clk);
      rst_n = 1'b1;

      // ---------------- table ----------------
      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].start, vecs[i].ack, vecs[i].rdata,
               vecs[i].ready, vecs[i].rv, vecs[i].rpc);
         #1;
         chk($sformatf("v%0d_req", i),   {7'd0, imem_req},    {7'd0, vecs[i].req});
         chk($sformatf("v%0d_addr", i),  imem_addr,           vecs[i].addr);
         chk($sformatf("v%0d_valid", i), {7'd0, instr_valid}, {7'd0, vecs[i].valid});
         chk($sformatf("v%0d_instr", i), instr,               vecs[i].ins);
         chk($sformatf("v%0d_op", i),    {5'd0, opcode},      {5'd0, vecs[i].ins[7:5]});
         chk($sformatf("v%0d_pc", i),    pc,                  vecs[i].pcv);
         chk($sformatf("v%0d_ill", i),   {7'd0, illegal_op},  {7'd0, vecs[i].ill});
         chk($sformatf("v%0d_halt", i),  {7'd0, halted},      {7'd0, vecs[i].hlt});
         $display("vec %0d: req=%0b addr=%h valid=%0b instr=%h pc=%h halted=%0b",
                  i, imem_req, imem_addr, instr_valid, instr, pc, halted);
         @(negedge clk);
      end

      // ---------------- illegal 0x3F at 0x05 ----------------
      do_reset();
      drive(1, 0, 8'h00, 0, 0, 8'h00);
      @(negedge clk);
      drive(0, 1, 8'h00, 0, 0, 8'h00);            // ADD at 0x00
      @(negedge clk);
      drive(0, 0, 8'h00, 1, 1, 8'h05);            // handshake, redirect to 0x05
      #1;
      chk("ill_issue_valid", {7'd0, instr_valid}, 8'h01);
      @(negedge clk);
      drive(0, 1, 8'h3F, 0, 0, 8'h00);
      #1;
      chk("ill_fetch_addr", imem_addr, 8'h05);
      chk("ill_fetch_req", {7'd0, imem_req}, 8'h01);
      @(negedge clk);
      drive(1, 0, 8'h00, 1, 0, 8'h00);            // start pulse in HALT
      #1;
      chk("ill_halted", {7'd0, halted},     8'h01);
      chk("ill_flag",   {7'd0, illegal_op}, 8'h01);
      chk("ill_pc",     pc,                 8'h05);
      chk("ill_instr",  instr,              8'h00);
      $display("seq illegal: halted=%0b illegal_op=%0b pc=%h", halted, illegal_op, pc);
      @(negedge clk);
      drive(0, 1, 8'h00, 1, 0, 8'h00);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("ill_hold%0d_req", k),   {7'd0, imem_req},    8'h00);
         chk($sformatf("ill_hold%0d_valid", k), {7'd0, instr_valid}, 8'h00);
         chk($sformatf("ill_hold%0d_halt", k),  {7'd0, halted},      8'h01);
         @(negedge clk);
      end

      // ---------------- async reset mid-FETCH ----------------
      do_reset();
      drive(1, 0, 8'h00, 0, 0, 8'h00);
      @(negedge clk);
      drive(0, 1, 8'h9A, 0, 0, 8'h00);
      @(negedge clk);
      drive(0, 0, 8'h00, 1, 1, 8'h33);
      @(negedge clk);
      drive(0, 0, 8'h00, 0, 0, 8'h00);            // FETCH at 0x33, no ack
      #1;
      chk("ar_req_before",  {7'd0, imem_req}, 8'h01);
      chk("ar_addr_before", imem_addr,        8'h33);
      #1;
      rst_n = 1'b0;
      #1;                                         // still before the next edge
      chk("ar_req_after", {7'd0, imem_req},    8'h00);
      chk("ar_pc_after",  pc,                  8'h00);
      chk("ar_instr",     instr,               8'h00);
      chk("ar_valid",     {7'd0, instr_valid}, 8'h00);
      $display("seq async reset: req=%0b pc=%h", imem_req, pc);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1, 0, 8'h00, 0, 0, 8'h00);
      @(negedge clk);
      drive(0, 1, 8'h05, 0, 0, 8'h00);
      #1;
      chk("ar_resume_req",  {7'd0, imem_req}, 8'h01);
      chk("ar_resume_addr", imem_addr,        8'h00);
      @(negedge clk);
      drive(0, 0, 8'h00, 1, 0, 8'h00);
      #1;
      chk("ar_resume_instr", instr,               8'h05);
      chk("ar_resume_valid", {7'd0, instr_valid}, 8'h01);
      @(negedge clk);
      drive(0, 0, 8'h00, 0, 0, 8'h00);
      #1;
      chk("ar_next_addr", imem_addr, 8'h01);
      $display("seq resume: addr=%h instr=%h", imem_addr, instr);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction-side initiator for the 8-bit non-pipelined core. It holds the PC, fetches one 8-bit instruction at a time from instruction memory over a req/ack handshake, and screens the 3-bit opcode against the decoder's legal set (000 ADD, 100 ADDI, 111 SLL, 110 LW, 101 SW). It presents legal instructions to the control unit over a valid/ready handshake. An illegal opcode (001, 010, 011) halts the unit, so the decoder never sees an opcode that yields X controls.

Parameters:
ADDR_W, 8, PC and instruction-memory address width.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse; begins fetching from the current PC; used in IDLE only.
imem_req  out  1  fetch request to instruction memory.
imem_addr  out  ADDR_W  fetch address; equals pc.
imem_ack  in  1  memory has valid imem_rdata this cycle.
imem_rdata  in  8  instruction word; sampled only on imem_req && imem_ack.
instr_valid  out  1  instr/opcode valid toward decode.
instr_ready  in  1  decode/execute accepts the instruction.
instr  out  8  registered instruction word.
opcode  out  3  instr[7:5]; drives the control unit opcode input.
pc  out  ADDR_W  address of the instruction held in instr.
redirect_valid  in  1  next PC is redirect_pc instead of pc+1.
redirect_pc  in  ADDR_W  redirect target.
illegal_op  out  1  sticky; an illegal opcode was fetched.
halted  out  1  high in the HALT state.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, instr=8'h00, instr_valid=0, illegal_op=0. imem_req and halted are decoded from state, so both go to 0 immediately.
- States: IDLE, FETCH, ISSUE, HALT.
- IDLE: all outputs idle. start=1 moves the state to FETCH on the next edge.
- FETCH:
  - imem_req=1 and imem_addr=pc, held stable until imem_ack.
  - On ack with a legal imem_rdata[7:5]: load instr, then go to ISSUE. instr_valid rises on the next cycle.
  - On ack with an illegal opcode: instr is not loaded and instr_valid stays 0. illegal_op<=1, then go to HALT.
- ISSUE:
  - instr_valid=1. instr, opcode and pc stay stable until instr_ready=1.
  - Handshake (valid&&ready): pc<=redirect_valid ? redirect_pc : pc+1, then go to FETCH.
- HALT: terminal state. halted=1, pc holds the address of the illegal word, no requests are issued. Only rst_n exits HALT.
- Arithmetic: pc+1 is modulo 2^ADDR_W, so all-ones wraps to 0 with no flag.
- Throughput: 2 cycles per instruction with zero-wait memory (ack in the first FETCH cycle) and instr_ready held high. Each memory wait cycle or ready-low cycle adds 1 cycle.
- Ignored inputs:
  - start outside IDLE.
  - imem_ack and imem_rdata outside FETCH.
  - redirect_valid except in the handshake cycle.
  - instr_ready outside ISSUE.
- Simultaneous events: redirect_valid and instr_ready in the same cycle means the redirect wins.
- Reset mid-operation: an outstanding request is abandoned without waiting for ack, and a held instruction is dropped. The memory must tolerate an aborted request.
- instr_valid never depends combinationally on instr_ready. imem_req never depends combinationally on imem_ack.

Test Plan:
1. Zero-wait fetch, ready=1: memory holds 0x00:0x9A, 0x01:0x05. Release reset, pulse start -> imem_addr 0x00. Instructions issue 2 cycles apart: opcode 100 with pc=0x00, then opcode 000 with pc=0x01. imem_addr 0x02 is requested after the second handshake.
2. Backpressure: instr_ready low 5 cycles in ISSUE -> instr_valid=1 and instr/opcode/pc constant for all 5 cycles, imem_req=0 throughout. Fetch resumes one cycle after ready rises.
3. Memory wait states: ack delayed 3 cycles, with junk on imem_rdata before ack -> imem_req=1 and imem_addr constant for 4 cycles. Only the word present in the ack cycle appears on instr.
4. Illegal opcode: 0x3F (opcode 001) at 0x05 -> halted=1 and illegal_op=1 the next cycle, instr_valid never asserted, pc=0x05, no further imem_req. A start pulse has no effect.
5. Redirect and wrap-around:
   - Handshake with redirect_valid=1, redirect_pc=0x40 -> next imem_addr=0x40.
   - Handshake at pc=0xFF without redirect -> next imem_addr=0x00.
6. Async reset mid-FETCH: assert rst_n=0 while imem_req=1 -> imem_req=0 before the next clock edge, pc=RESET_PC. After a new start pulse, fetching resumes at RESET_PC.
